// File: rtl/counter_sched.sv
// Round-robin arbiter granting one requester at a time use of a shared W-bit down-counter.
// Latency: grant 1 cycle after req seen in IDLE; grant lasts len+2 cycles (len=0: 2), done in last.
// Backpressure: requests wait at req level while busy; optional COUNTER_SCHED_ABORT_EN lets a dropped req abort service.
module counter_sched #(
  parameter int NREQ = 4,
  parameter int W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_len,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic [W-1:0]      value
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] idx;
  logic [W-1:0]  len;

  logic          pick_vld;
  logic [IW-1:0] pick;
  logic [W-1:0]  pick_len;
  logic [IW-1:0] idx_nxt;
  logic          req_drop;

  // Modulo-NREQ add; NREQ need not be a power of two, so wrap explicitly.
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s >= NREQ) s = s - NREQ;
    return IW'(s);
  endfunction

  // Round-robin pick: first set req bit scanning ptr, ptr+1, ... with wrap.
  // Scanning from the far end downward lets the closest candidate overwrite the others.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[wrap_add(ptr, k)]) begin
        pick_vld = 1'b1;
        pick     = wrap_add(ptr, k);
      end
    end
  end

  // Length of the candidate and the pointer value that follows the current owner.
  always_comb begin
    pick_len = req_len[pick*W +: W];
    idx_nxt  = wrap_add(idx, 1);
  end

`ifdef COUNTER_SCHED_ABORT_EN
  // Owner withdrew its request: service is abandoned before completion.
  always_comb req_drop = ~req[idx];
`else
  // Owner's req is not looked at once granted; service always completes.
  always_comb req_drop = 1'b0;
`endif

  // Scheduler FSM with registered grant/done/busy/value outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ptr   <= '0;
      idx   <= '0;
      len   <= '0;
      grant <= '0;
      done  <= '0;
      busy  <= 1'b0;
      value <= '0;
    end else begin
      done <= '0;
      unique case (state)
        IDLE: begin
          if (pick_vld) begin
            state <= LOAD;
            idx   <= pick;
            len   <= pick_len;
            grant <= NREQ'(1) << pick;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          if (req_drop) begin
            state <= IDLE;
            grant <= '0;
            busy  <= 1'b0;
            value <= '0;
            ptr   <= idx_nxt;
          end else begin
            value <= len;
            if (len != '0) begin
              state <= COUNT;
            end else begin
              state <= DONE;
              done  <= grant;
            end
          end
        end
        COUNT: begin
          if (req_drop) begin
            state <= IDLE;
            grant <= '0;
            busy  <= 1'b0;
            value <= '0;
            ptr   <= idx_nxt;
          end else if (value <= W'(1)) begin
            // Last count step lands on zero; never wraps below it.
            value <= '0;
            state <= DONE;
            done  <= grant;
          end else begin
            value <= value - W'(1);
          end
        end
        DONE: begin
          // Owner drops to lowest priority for the next arbitration round.
          state <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
          value <= '0;
          ptr   <= idx_nxt;
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
          value <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_sched.sv
// Bench for counter_sched: directed scenarios plus randomized requesters.
// Expected outputs come from a service-timeline model (owner, length, cycles elapsed).
// Inputs change on the falling edge; outputs are compared on the falling edge.
module tb_counter_sched;

  localparam int NREQ = 4;
  localparam int W    = 8;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] req_len;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic              busy;
  logic [W-1:0]      value;

  int checks = 0;
  int errs   = 0;

  // Model: a service is "in progress" for len+2 cycles (LOAD, len counts, DONE).
  bit m_srv;
  int m_own;
  int m_len;
  int m_t;
  int m_ptr;

  logic [W-1:0]    svc_vals[$];
  int              st_idx[$];
  int              st_cyc[$];
  logic [NREQ-1:0] pg;
  int              exp_order[5] = '{0, 1, 2, 3, 0};
  int              exp_single[5] = '{0, 3, 2, 1, 0};
  bit              found;

  counter_sched #(.NREQ(NREQ), .W(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .req_len (req_len),
    .grant   (grant),
    .done    (done),
    .busy    (busy),
    .value   (value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_srv = 1'b0;
    m_ptr = 0;
    m_own = 0;
    m_len = 0;
    m_t   = 0;
  endtask

  // Advance the model by one rising edge using the inputs present at that edge.
  task automatic model_edge();
    if (!reset) begin
      model_reset();
    end else if (!m_srv) begin
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (m_ptr + k) % NREQ;
        if (req[j]) begin
          m_srv = 1'b1;
          m_own = j;
          m_len = int'(req_len[j*W +: W]);
          m_t   = 0;
          break;
        end
      end
    end else if (m_t == m_len + 1) begin
      m_srv = 1'b0;
      m_ptr = (m_own + 1) % NREQ;
    end
`ifdef COUNTER_SCHED_ABORT_EN
    else if (!req[m_own]) begin
      m_srv = 1'b0;
      m_ptr = (m_own + 1) % NREQ;
    end
`endif
    else begin
      m_t++;
    end
  endtask

  function automatic logic [NREQ-1:0] e_grant();
    return m_srv ? (NREQ'(1) << m_own) : '0;
  endfunction

  function automatic logic [NREQ-1:0] e_done();
    return (m_srv && m_t == m_len + 1) ? (NREQ'(1) << m_own) : '0;
  endfunction

  function automatic int e_value();
    return (m_srv && m_t >= 1 && m_t <= m_len) ? (m_len - m_t + 1) : 0;
  endfunction

  function automatic int oh_idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [W-1:0] rand_len();
    if ($urandom_range(0, 9) == 0) return W'($urandom_range(0, 40));
    return W'($urandom_range(0, 5));
  endfunction

  task automatic compare_all();
    chk("grant", 32'(grant), 32'(e_grant()));
    chk("done", 32'(done), 32'(e_done()));
    chk("busy", 32'(busy), 32'(m_srv));
    chk("value", 32'(value), 32'(e_value()));
    chk("onehot", 32'($onehot0(grant) && $onehot0(done) && ((done & ~grant) == '0)), 32'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Run until one service begins and ends; owner drops req on its done.
  task automatic serve_one(input string tag, input int exp_cycles);
    int gc;
    int dpos;
    bit seen;
    gc   = 0;
    dpos = 0;
    seen = 1'b0;
    svc_vals.delete();
    for (int n = 0; n < 600; n++) begin
      tick();
      if (grant != '0) begin
        seen = 1'b1;
        gc++;
        svc_vals.push_back(value);
        if (done != '0) begin
          dpos = gc;
          req  = '0;
        end
      end else if (seen) begin
        break;
      end
    end
    chk({tag, "_grant_cycles"}, 32'(gc), 32'(exp_cycles));
    chk({tag, "_done_pos"}, 32'(dpos), 32'(exp_cycles));
  endtask

  task automatic wait_value(input string tag, input int v);
    for (int n = 0; n < 400 && int'(value) != v; n++) tick();
    chk(tag, 32'(value), 32'(v));
  endtask

  task automatic drain();
    req = '0;
    for (int n = 0; n < 600 && (m_srv || grant != '0); n++) tick();
    chk("drain_idle", 32'(grant), 32'd0);
    tick();
  endtask

  initial begin
    reset   = 1'b0;
    req     = '0;
    req_len = '0;
    model_reset();
    tick();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_value", 32'(value), 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // Single request, length 3.
    req_len[0*W +: W] = 8'd3;
    req = 4'b0001;
    serve_one("single", 5);
    for (int i = 0; i < 5; i++)
      chk("single_val", (i < svc_vals.size()) ? 32'(svc_vals[i]) : 32'hdead, 32'(exp_single[i]));

    // Zero length.
    req_len[2*W +: W] = 8'd0;
    req = 4'b0100;
    serve_one("zero", 2);
    for (int i = 0; i < 2; i++)
      chk("zero_val", (i < svc_vals.size()) ? 32'(svc_vals[i]) : 32'hdead, 32'd0);

    // Full contention from a fresh pointer.
    do_reset();
    for (int i = 0; i < NREQ; i++) req_len[i*W +: W] = 8'd2;
    req = 4'b1111;
    pg  = '0;
    for (int n = 0; n < 30; n++) begin
      tick();
      if (grant != '0 && pg == '0) begin
        st_idx.push_back(oh_idx(grant));
        st_cyc.push_back(n);
      end
      pg = grant;
    end
    chk("cont_nstarts", 32'(st_idx.size() >= 5), 32'd1);
    for (int i = 0; i < 5; i++)
      chk("cont_order", (i < st_idx.size()) ? 32'(st_idx[i]) : 32'hffff_ffff, 32'(exp_order[i]));
    for (int i = 1; i < 5; i++)
      chk("cont_spacing", (i < st_cyc.size()) ? 32'(st_cyc[i] - st_cyc[i-1]) : 32'hffff_ffff, 32'd5);
    drain();

    // Round-robin skip: after serving 1, requester 0 wins over 1.
    req_len[0*W +: W] = 8'd1;
    req_len[1*W +: W] = 8'd1;
    req = 4'b0010;
    serve_one("rr1", 3);
    req = 4'b0011;
    tick();
    chk("rr_skip", 32'(grant), 32'h1);
    drain();

    // Asynchronous reset in the middle of a long count.
    req_len[0*W +: W] = 8'd200;
    req = 4'b0001;
    wait_value("arst_wait", 100);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("arst_grant", 32'(grant), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_value", 32'(value), 32'd0);
    tick();
    tick();
    req = 4'b0010;
    req_len[1*W +: W] = 8'd2;
    reset = 1'b1;
    tick();
    chk("arst_regrant", 32'(grant), 32'h2);
    drain();

    // Requester 3 withdraws mid-count.
    req_len[3*W +: W] = 8'd10;
    req = 4'b1000;
    wait_value("abort_wait", 6);
    req = 4'b0000;
    tick();
`ifdef COUNTER_SCHED_ABORT_EN
    chk("abort_grant", 32'(grant), 32'd0);
    chk("abort_value", 32'(value), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
`else
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      if (done[3]) found = 1'b1;
      else tick();
    end
    chk("noabort_done", 32'(found), 32'd1);
    chk("noabort_value", 32'(value), 32'd0);
`endif
    drain();

    // Randomized requesters that mostly follow the hold-until-done handshake.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            req[i] = 1'b1;
            req_len[i*W +: W] = rand_len();
          end
        end else if (done[i]) begin
          if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
          else req_len[i*W +: W] = rand_len();
        end else if (grant[i] && $urandom_range(0, 39) == 0) begin
          req[i] = 1'b0;
        end
      end
      tick();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
